// File: rtl/exhaustive_vector_sweeper.sv
// ============================================================================
// exhaustive_vector_sweeper: sweeps every IN_W-bit vector into a DUT, streams
// (vector, response) records over valid/ready and folds them into a MISR.
// Revision: 1.0
// ============================================================================
`default_nettype none

module exhaustive_vector_sweeper #(
  parameter int               IN_W     = 5,
  parameter int               OUT_W    = 1,
  parameter int               SETTLE   = 1,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] POLY     = 16'h1021,
  parameter logic [SIG_W-1:0] SIG_SEED = 16'h0000
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [IN_W-1:0]  rec_vec,
  output logic [OUT_W-1:0] rec_resp,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [IN_W-1:0]  VEC_LAST    = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [OUT_W-1:0] resp);
    misr_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(resp);
  endfunction

  // dut_in doubles as the sweep vector counter, so the DUT sees it directly.
  always_ff @(posedge CK) begin
    if (reset) begin
      state      <= S_IDLE;
      dut_in     <= '0;
      settle_cnt <= '0;
      rec_valid  <= 1'b0;
      rec_vec    <= '0;
      rec_resp   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= SIG_SEED;
    end else if (abort) begin
      state      <= S_IDLE;
      dut_in     <= '0;
      settle_cnt <= '0;
      rec_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      signature  <= SIG_SEED;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_APPLY;
            dut_in     <= '0;
            signature  <= SIG_SEED;
            settle_cnt <= SETTLE_LAST;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        S_APPLY: begin
          if (settle_cnt == '0) begin
            rec_resp  <= dut_out;
            rec_vec   <= dut_in;
            rec_valid <= 1'b1;
            state     <= S_EMIT;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        S_EMIT: begin
          // Record, vector and signature stay frozen until the consumer accepts.
          if (rec_ready) begin
            rec_valid <= 1'b0;
            signature <= misr_next(signature, rec_resp);
            if (dut_in == VEC_LAST) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              dut_in     <= dut_in + IN_W'(1);
              settle_cnt <= SETTLE_LAST;
              state      <= S_APPLY;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exhaustive_vector_sweeper.sv
// ============================================================================
// tb_exhaustive_vector_sweeper: directed checks of three sweeper configurations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_exhaustive_vector_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_mis = 0;

  // Instance A: 5-bit parity DUT, SETTLE=1
  logic        start_a = 0, abort_a = 0, rec_ready_a = 1;
  logic [4:0]  dut_in_a, rec_vec_a;
  logic        dut_out_a, rec_valid_a, rec_resp_a, busy_a, done_a;
  logic [15:0] signature_a;
  assign dut_out_a = ^dut_in_a;

  exhaustive_vector_sweeper #(.IN_W(5), .OUT_W(1), .SETTLE(1)) u_a (
    .CK(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .dut_in(dut_in_a), .dut_out(dut_out_a), .rec_valid(rec_valid_a),
    .rec_ready(rec_ready_a), .rec_vec(rec_vec_a), .rec_resp(rec_resp_a),
    .busy(busy_a), .done(done_a), .signature(signature_a));

  // Instance B: 2-bit sweep, constant DUT response
  logic        start_b = 0, abort_b = 0, rec_ready_b = 1, const_b = 1;
  logic [1:0]  dut_in_b, rec_vec_b;
  logic        rec_valid_b, rec_resp_b, busy_b, done_b;
  logic [15:0] signature_b;

  exhaustive_vector_sweeper #(.IN_W(2), .OUT_W(1), .SETTLE(1)) u_b (
    .CK(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .dut_in(dut_in_b), .dut_out(const_b), .rec_valid(rec_valid_b),
    .rec_ready(rec_ready_b), .rec_vec(rec_vec_b), .rec_resp(rec_resp_b),
    .busy(busy_b), .done(done_b), .signature(signature_b));

  // Instance C: 3-bit sweep, SETTLE=3, two-stage registered loopback
  logic        start_c = 0, abort_c = 0, rec_ready_c = 1;
  logic [2:0]  dut_in_c, rec_vec_c, rec_resp_c, pipe1_c, pipe2_c;
  logic        rec_valid_c, busy_c, done_c;
  logic [15:0] signature_c;
  always @(posedge clk) begin
    pipe1_c <= dut_in_c;
    pipe2_c <= pipe1_c;
  end

  exhaustive_vector_sweeper #(.IN_W(3), .OUT_W(3), .SETTLE(3)) u_c (
    .CK(clk), .reset(reset), .start(start_c), .abort(abort_c),
    .dut_in(dut_in_c), .dut_out(pipe2_c), .rec_valid(rec_valid_c),
    .rec_ready(rec_ready_c), .rec_vec(rec_vec_c), .rec_resp(rec_resp_c),
    .busy(busy_c), .done(done_c), .signature(signature_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] sig, input logic resp);
    misr = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {15'd0, resp};
  endfunction

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1;
    @(negedge clk) start_a = 0;
  endtask

  // Consume one sweep of A; optionally stall at stall_vec (start held high then).
  task automatic sweep_a(input int stall_vec, input int stall_len,
                         output int nrec, output int done_edge, output logic [15:0] sig);
    logic [4:0] ev;
    int stalled, edges;
    ev = '0; stalled = 0; edges = 0; nrec = 0; done_edge = -1; sig = 16'h0000;
    rec_ready_a = 1;
    for (int cyc = 0; cyc < 400 && done_edge < 0; cyc++) begin
      @(negedge clk);
      edges++;
      if (done_a) done_edge = edges;
      else if (rec_valid_a) begin
        if (int'(rec_vec_a) == stall_vec && stalled < stall_len) begin
          rec_ready_a = 0;
          start_a     = 1;
          stalled++;
          chk("stall_vec", rec_vec_a, stall_vec);
          chk("stall_resp", rec_resp_a, ^rec_vec_a);
          chk("stall_dut_in", dut_in_a, stall_vec);
        end else begin
          rec_ready_a = 1;
          start_a     = 0;
          chk("rec_vec", rec_vec_a, ev);
          chk("rec_resp", rec_resp_a, ^ev);
          sig = misr(sig, ^ev);
          ev  = ev + 5'd1;
          nrec++;
        end
      end
    end
    rec_ready_a = 1;
    start_a     = 0;
  endtask

  initial begin
    int          nrec, done_edge, edges;
    logic [15:0] sig1, sig2;
    logic [2:0]  evc;
    bit          hit;

    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_dut_in", dut_in_a, 0);
    chk("rst_rec_valid", rec_valid_a, 0);
    chk("rst_rec_vec", rec_vec_a, 0);
    chk("rst_rec_resp", rec_resp_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sig", signature_a, 16'h0000);

    // Full sweep, rec_ready held high
    pulse_start_a();
    chk("run1_busy", busy_a, 1);
    sweep_a(-1, 0, nrec, done_edge, sig1);
    chk("run1_count", nrec, 32);
    chk("run1_done_edge", done_edge, 64);
    chk("run1_sig", signature_a, sig1);
    chk("done_rec_valid", rec_valid_a, 0);
    chk("done_busy", busy_a, 0);
    chk("done_dut_in", dut_in_a, 31);
    repeat (3) @(negedge clk);
    chk("done_sig_frozen", signature_a, sig1);
    chk("done_held", done_a, 1);

    // Rerun from DONE with a 5-cycle stall at vec 3 and start asserted mid-sweep
    pulse_start_a();
    chk("rerun_done_drop", done_a, 0);
    chk("rerun_busy", busy_a, 1);
    chk("rerun_seed", signature_a, 16'h0000);
    sweep_a(3, 5, nrec, done_edge, sig2);
    chk("run2_count", nrec, 32);
    chk("run2_done_edge", done_edge, 69);
    chk("run2_sig_same", signature_a, sig1);

    // Abort while record 10 is offered
    pulse_start_a();
    hit = 0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      if (rec_valid_a && rec_vec_a == 5'd10) hit = 1;
    end
    chk("abort_reach", hit, 1);
    abort_a = 1;
    @(negedge clk) abort_a = 0;
    chk("abort_busy", busy_a, 0);
    chk("abort_rec_valid", rec_valid_a, 0);
    chk("abort_dut_in", dut_in_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_sig", signature_a, 16'h0000);
    pulse_start_a();
    sweep_a(-1, 0, nrec, done_edge, sig2);
    chk("post_abort_count", nrec, 32);
    chk("post_abort_sig", signature_a, sig1);

    // Reset while stalled in EMIT
    pulse_start_a();
    hit = 0;
    for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
      @(negedge clk);
      if (rec_valid_a && rec_vec_a == 5'd7) hit = 1;
    end
    chk("reset_reach", hit, 1);
    rec_ready_a = 0;
    reset = 1;
    @(negedge clk) reset = 0;
    rec_ready_a = 1;
    chk("emit_rst_rec_valid", rec_valid_a, 0);
    chk("emit_rst_rec_vec", rec_vec_a, 0);
    chk("emit_rst_rec_resp", rec_resp_a, 0);
    chk("emit_rst_dut_in", dut_in_a, 0);
    chk("emit_rst_busy", busy_a, 0);
    chk("emit_rst_done", done_a, 0);
    chk("emit_rst_sig", signature_a, 16'h0000);
    @(negedge clk);
    chk("emit_rst_idle", busy_a, 0);

    // 2-bit sweep, constant response 1 then 0
    const_b = 1;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    edges = 0; done_edge = -1;
    for (int cyc = 0; cyc < 50 && done_edge < 0; cyc++) begin
      @(negedge clk);
      edges++;
      if (done_b) done_edge = edges;
    end
    chk("b1_done_edge", done_edge, 8);
    chk("b1_sig", signature_b, 16'h000F);
    const_b = 0;
    @(negedge clk) start_b = 1;
    @(negedge clk) start_b = 0;
    chk("b0_seed", signature_b, 16'h0000);
    done_edge = -1;
    for (int cyc = 0; cyc < 50 && done_edge < 0; cyc++) begin
      @(negedge clk);
      if (done_b) done_edge = cyc;
    end
    chk("b0_done", done_b, 1);
    chk("b0_sig", signature_b, 16'h0000);

    // SETTLE=3 with a two-cycle loopback: each response must equal its vector
    @(negedge clk) start_c = 1;
    @(negedge clk) start_c = 0;
    edges = 0; done_edge = -1; nrec = 0; evc = '0;
    for (int cyc = 0; cyc < 100 && done_edge < 0; cyc++) begin
      @(negedge clk);
      edges++;
      if (done_c) done_edge = edges;
      else if (rec_valid_c) begin
        chk("c_rec_vec", rec_vec_c, evc);
        chk("c_rec_resp", rec_resp_c, evc);
        evc = evc + 3'd1;
        nrec++;
      end
    end
    chk("c_count", nrec, 8);
    chk("c_done_edge", done_edge, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
